fallthrough_small_fifo: RTL and testbench

FALLTHROUGH_SMALL_FIFO -- requirements
Module: fallthrough_small_fifo

---
 rtl/fallthrough_small_fifo.sv | 110 +++++++++++
 tb/tb_fallthrough_small_fifo.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fallthrough_small_fifo.sv
// Small show-ahead FIFO: the oldest word sits on dout while empty=0 and rd_en pops it.
// Status flags are registered copies computed from the next-cycle occupancy.
module fallthrough_small_fifo #(
    parameter int unsigned WIDTH               = 72,
    parameter int unsigned MAX_DEPTH_BITS      = 3,
    parameter int unsigned PROG_FULL_THRESHOLD = (2 ** MAX_DEPTH_BITS) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             prog_full,
    output logic             empty
);

    localparam int unsigned DEPTH = 2 ** MAX_DEPTH_BITS;
    localparam int unsigned PW    = MAX_DEPTH_BITS;
    localparam int unsigned CW    = MAX_DEPTH_BITS + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             nearly_full_q, nearly_full_d;
    logic             prog_full_q, prog_full_d;
    logic             wr_accept_c;
    logic             rd_accept_c;

    // Next-state: accept decisions use only registered flags, so a read never frees a full slot same-cycle.
    always_comb begin
        wr_accept_c = wr_en && !full_q;
        rd_accept_c = rd_en && !empty_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (wr_accept_c) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (rd_accept_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({wr_accept_c, rd_accept_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        empty_d       = (count_d == '0);
        full_d        = (count_d == CW'(DEPTH));
        nearly_full_d = (count_d >= CW'(DEPTH - 1));
        prog_full_d   = (32'(count_d) >= 32'(PROG_FULL_THRESHOLD));
    end

    // Storage is intentionally not reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            nearly_full_q <= 1'b0;
            prog_full_q   <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            empty_q       <= empty_d;
            full_q        <= full_d;
            nearly_full_q <= nearly_full_d;
            prog_full_q   <= prog_full_d;
        end
    end

    assign dout        = mem_q[rd_ptr_q];
    assign empty       = empty_q;
    assign full        = full_q;
    assign nearly_full = nearly_full_q;
    assign prog_full   = prog_full_q;

`ifndef SYNTHESIS
    // Simulation-only misuse reporting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_en && full_q) begin
                $warning("fallthrough_small_fifo: overflow, write while full ignored");
            end
            if (rd_en && empty_q) begin
                $warning("fallthrough_small_fifo: underflow, read while empty ignored");
            end
        end
    end
`endif

endmodule

// File: tb/tb_fallthrough_small_fifo.sv
// Directed bench: a vector table for the 8-bit/4-deep instance plus hand sequences
// for throughput, async reset, and the default 72-bit/8-deep instance.
module tb_fallthrough_small_fifo;

    typedef struct {
        logic       rst;
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [3:0] flags;   // {empty, full, nearly_full, prog_full}
        logic       chk;
        logic [7:0] dout;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_din;
    logic        s_wr, s_rd;
    logic [7:0]  s_dout;
    logic        s_full, s_nf, s_pf, s_empty;
    logic [71:0] b_din;
    logic        b_wr, b_rd;
    logic [71:0] b_dout;
    logic        b_full, b_nf, b_pf, b_empty;

    int n_total = 0;
    int n_pass  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fallthrough_small_fifo #(.WIDTH(8), .MAX_DEPTH_BITS(2)) u_small (
        .clk(clk), .reset(rst), .din(s_din), .wr_en(s_wr), .rd_en(s_rd),
        .dout(s_dout), .full(s_full), .nearly_full(s_nf), .prog_full(s_pf), .empty(s_empty)
    );

    fallthrough_small_fifo u_big (
        .clk(clk), .reset(rst), .din(b_din), .wr_en(b_wr), .rd_en(b_rd),
        .dout(b_dout), .full(b_full), .nearly_full(b_nf), .prog_full(b_pf), .empty(b_empty)
    );

    function automatic vec_t v(input logic r, input logic w, input logic d_rd, input logic [7:0] di,
                               input logic [3:0] fl, input logic c, input logic [7:0] dq);
        vec_t t;
        t.rst = r; t.wr = w; t.rd = d_rd; t.din = di; t.flags = fl; t.chk = c; t.dout = dq;
        return t;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] big_word(input int i);
        return {8'(i), 64'hDEAD_BEEF_0000_0000 + 64'(i)};
    endfunction

    initial begin
        rst = 1'b1; s_wr = 0; s_rd = 0; s_din = '0; b_wr = 0; b_rd = 0; b_din = '0;

        //          rst wr rd din    {e,f,nf,pf} chk dout
        vecs.push_back(v(1, 0, 0, 8'h00, 4'b1000, 0, 8'h00));
        vecs.push_back(v(0, 1, 0, 8'h11, 4'b0000, 1, 8'h11));
        vecs.push_back(v(0, 0, 0, 8'h00, 4'b0000, 1, 8'h11));
        vecs.push_back(v(0, 0, 1, 8'h00, 4'b1000, 0, 8'h00));
        vecs.push_back(v(0, 1, 0, 8'h01, 4'b0000, 1, 8'h01));
        vecs.push_back(v(0, 1, 0, 8'h02, 4'b0000, 1, 8'h01));
        vecs.push_back(v(0, 1, 0, 8'h03, 4'b0011, 1, 8'h01));
        vecs.push_back(v(0, 1, 0, 8'h04, 4'b0111, 1, 8'h01));
        vecs.push_back(v(0, 1, 0, 8'h05, 4'b0111, 1, 8'h01));
        vecs.push_back(v(0, 0, 1, 8'h00, 4'b0011, 1, 8'h02));
        vecs.push_back(v(0, 0, 1, 8'h00, 4'b0000, 1, 8'h03));
        vecs.push_back(v(0, 0, 1, 8'h00, 4'b0000, 1, 8'h04));
        vecs.push_back(v(0, 0, 1, 8'h00, 4'b1000, 0, 8'h00));
        vecs.push_back(v(0, 0, 1, 8'h00, 4'b1000, 0, 8'h00));
        vecs.push_back(v(0, 0, 1, 8'h00, 4'b1000, 0, 8'h00));
        vecs.push_back(v(0, 0, 1, 8'h00, 4'b1000, 0, 8'h00));
        vecs.push_back(v(0, 1, 1, 8'hAA, 4'b0000, 1, 8'hAA));
        vecs.push_back(v(0, 0, 1, 8'h00, 4'b1000, 0, 8'h00));
        vecs.push_back(v(0, 1, 0, 8'h31, 4'b0000, 1, 8'h31));
        vecs.push_back(v(0, 1, 0, 8'h32, 4'b0000, 1, 8'h31));
        vecs.push_back(v(0, 1, 0, 8'h33, 4'b0011, 1, 8'h31));
        vecs.push_back(v(0, 1, 0, 8'h34, 4'b0111, 1, 8'h31));
        vecs.push_back(v(0, 1, 1, 8'h99, 4'b0011, 1, 8'h32));
        vecs.push_back(v(0, 0, 1, 8'h00, 4'b0000, 1, 8'h33));
        vecs.push_back(v(0, 0, 1, 8'h00, 4'b0000, 1, 8'h34));
        vecs.push_back(v(0, 0, 1, 8'h00, 4'b1000, 0, 8'h00));

        foreach (vecs[i]) begin
            rst = vecs[i].rst; s_wr = vecs[i].wr; s_rd = vecs[i].rd; s_din = vecs[i].din;
            tick();
            check($sformatf("vec%0d flags", i), 72'({s_empty, s_full, s_nf, s_pf}), 72'(vecs[i].flags));
            if (vecs[i].chk) check($sformatf("vec%0d dout", i), 72'(s_dout), 72'(vecs[i].dout));
            @(negedge clk);
        end

        // Concurrent read+write at occupancy 2 keeps occupancy steady and the stream gapless.
        s_rd = 0; s_wr = 1; s_din = 8'h20;
        tick(); @(negedge clk);
        s_din = 8'h21;
        tick(); @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            s_wr = 1; s_rd = 1; s_din = 8'(8'h22 + i);
            tick();
            check($sformatf("rw%0d dout", i), 72'(s_dout), 72'(8'h21 + i));
            check($sformatf("rw%0d flags", i), 72'({s_empty, s_full, s_nf, s_pf}), 72'(4'b0000));
            @(negedge clk);
        end
        s_wr = 0; s_rd = 1;
        tick();
        check("rw drain dout", 72'(s_dout), 72'(8'h2B));
        @(negedge clk);
        tick();
        check("rw drain empty", 72'(s_empty), 72'(1'b1));
        @(negedge clk);

        // Asynchronous reset mid-operation at occupancy 3.
        s_rd = 0; s_wr = 1;
        for (int i = 0; i < 3; i++) begin
            s_din = 8'(8'h41 + i);
            tick(); @(negedge clk);
        end
        s_wr = 0;
        check("pre-reset nearly_full", 72'({s_empty, s_nf}), 72'(2'b01));
        #2 rst = 1'b1;
        #1;
        check("async reset flags", 72'({s_empty, s_full, s_nf, s_pf}), 72'(4'b1000));
        rst = 1'b0;
        s_wr = 1; s_din = 8'h55;
        tick();
        check("post-reset write", 72'({s_empty, s_dout}), 72'({1'b0, 8'h55}));
        @(negedge clk);
        s_wr = 0; s_rd = 1;
        tick();
        check("post-reset pop", 72'(s_empty), 72'(1'b1));
        @(negedge clk);
        s_rd = 0;

        // Default-parameter instance: threshold flags and full at eight.
        for (int k = 1; k <= 8; k++) begin
            b_wr = 1; b_din = big_word(k - 1);
            tick();
            check($sformatf("big fill%0d flags", k), 72'({b_empty, b_full, b_nf, b_pf}),
                  72'({1'b0, k == 8, k >= 7, k >= 7}));
            check($sformatf("big fill%0d dout", k), b_dout, big_word(0));
            @(negedge clk);
        end
        b_din = 72'hFF; // dropped: FIFO is full
        tick(); @(negedge clk);
        b_wr = 0; b_rd = 1;
        for (int j = 1; j <= 8; j++) begin
            tick();
            if (j < 8) check($sformatf("big pop%0d dout", j), b_dout, big_word(j));
            else       check("big drained", 72'(b_empty), 72'(1'b1));
            @(negedge clk);
        end
        b_rd = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
